// File: rtl/instruction_fetch.sv
// Instruction fetch front end: sequential PC generation, imem request/response, decode-facing buffer.
// Latency: request issued the cycle after reset/redirect; response visible to decode one edge after it returns.
// Backpressure: credit of FIFO_DEPTH shared by in-flight requests and buffered words; decode stalls hold fetch.

module instruction_fetch_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       push_vld,
    input  logic [W-1:0]               push_dat,
    input  logic                       pop_rdy,
    output logic                       out_vld,
    output logic [W-1:0]               out_dat,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop;

    assign pop     = pop_rdy && (count != '0);
    assign out_vld = (count != '0);
    assign out_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push_vld) - CW'(pop);
        end
    end
endmodule

module instruction_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] instruction,
    output logic [31:0] inst_pc
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]   fetch_pc;
    logic [31:0]   rsp_pc;
    logic [31:0]   target_pc;
    logic [CW-1:0] inflight;
    logic [CW-1:0] drop;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   credit_used;
    logic          req_fire;
    logic          rsp_fire;
    logic          push;

    // Buffered words count against the credit so every in-flight word has a slot waiting.
    assign credit_used    = {1'b0, inflight} + {1'b0, fifo_count};
    assign imem_req_valid = !reset && !redirect_valid && (credit_used < (CW+1)'(FIFO_DEPTH));
    assign imem_req_addr  = fetch_pc;

    assign req_fire  = imem_req_valid && imem_req_ready;
    assign rsp_fire  = imem_rsp_valid && (inflight != '0);
    assign push      = rsp_fire && (drop == '0) && !redirect_valid;
    assign target_pc = {redirect_pc[31:2], 2'b00};

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
            inflight <= '0;
            drop     <= '0;
        end else begin
            inflight <= inflight + CW'(req_fire) - CW'(rsp_fire);
            if (redirect_valid) begin
                fetch_pc <= target_pc;
                rsp_pc   <= target_pc;
                drop     <= inflight - CW'(rsp_fire);
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (rsp_fire) begin
                    if (drop != '0) begin
                        drop <= drop - CW'(1);
                    end else begin
                        rsp_pc <= rsp_pc + 32'd4;
                    end
                end
            end
        end
    end

    instruction_fetch_fifo #(
        .W     (64),
        .DEPTH (FIFO_DEPTH)
    ) u_buf (
        .clk      (clk),
        .reset    (reset),
        .clear    (redirect_valid),
        .push_vld (push),
        .push_dat ({imem_rsp_data, rsp_pc}),
        .pop_rdy  (inst_ready),
        .out_vld  (inst_valid),
        .out_dat  ({instruction, inst_pc}),
        .count    (fifo_count)
    );
endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized bench for instruction_fetch against a transaction-level queue model.
module tb_instruction_fetch;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] instruction;
    logic [31:0] inst_pc;

    always #5 clk = ~clk;

    instruction_fetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .instruction    (instruction),
        .inst_pc        (inst_pc)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Outstanding memory transactions; stale = killed by redirect, ghost = survived a reset.
    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
        bit          ghost;
    } req_t;

    req_t        memq[$];
    logic [63:0] fq[$];
    logic [31:0] acc_log[$];
    logic [31:0] pop_log[$];
    logic [31:0] m_fetch_pc = RESET_PC;
    int          cyc        = 0;
    bit          prev_rst   = 1'b1;
    logic        obs_req_vld;
    logic [31:0] obs_req_addr;
    logic        obs_inst_vld;
    logic [31:0] obs_inst_pc;
    logic [31:0] obs_inst;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    task automatic cycle(input bit rst, input bit redir, input logic [31:0] rpc,
                         input bit rdy, input bit irdy, input int lat, input bit spur);
        bit   any_ghost = 1'b0;
        int   live      = 0;
        bit   rsp;
        bit   have      = 1'b0;
        bit   exp_req;
        bit   acc;
        req_t e;
        foreach (memq[i]) begin
            if (memq[i].ghost) any_ghost = 1'b1;
            else live++;
        end
        reset          = rst;
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_req_ready = rdy && !any_ghost;
        inst_ready     = irdy;
        rsp            = (memq.size() > 0) ? (memq[0].due <= cyc) : spur;
        imem_rsp_valid = rsp;
        if (memq.size() > 0)
            imem_rsp_data = memq[0].ghost ? ~word_of(memq[0].addr) : word_of(memq[0].addr);
        else
            imem_rsp_data = $urandom;
        exp_req = !rst && !redir && (live + fq.size() < DEPTH);

        @(negedge clk);
        obs_req_vld  = imem_req_valid;
        obs_req_addr = imem_req_addr;
        obs_inst_vld = inst_valid;
        obs_inst_pc  = inst_pc;
        obs_inst     = instruction;
        chk("req_valid", imem_req_valid, exp_req);
        if (exp_req) chk("req_addr", imem_req_addr, m_fetch_pc);
        chk("inst_valid", inst_valid, fq.size() > 0);
        if (fq.size() > 0) chk("inst_word_pc", {instruction, inst_pc}, fq[0]);
        if (prev_rst) chk("reset_outputs", {instruction, inst_pc}, 64'h0);

        acc = exp_req && imem_req_ready;
        if (rsp && memq.size() > 0) begin
            e    = memq.pop_front();
            have = 1'b1;
        end
        if (rst) begin
            fq.delete();
            foreach (memq[i]) memq[i].ghost = 1'b1;
            m_fetch_pc = RESET_PC;
        end else begin
            if (redir) begin
                fq.delete();
                foreach (memq[i]) memq[i].stale = 1'b1;
                m_fetch_pc = {rpc[31:2], 2'b00};
            end else begin
                if (fq.size() > 0 && irdy) begin
                    pop_log.push_back(fq[0][31:0]);
                    void'(fq.pop_front());
                end
                if (have && !e.stale && !e.ghost) fq.push_back({word_of(e.addr), e.addr});
            end
            if (acc) begin
                memq.push_back('{addr: m_fetch_pc, due: cyc + lat, stale: 1'b0, ghost: 1'b0});
                acc_log.push_back(m_fetch_pc);
                m_fetch_pc += 32'd4;
            end
        end
        prev_rst = rst;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset(input int n);
        repeat (n) cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1, 1'b0);
        acc_log.delete();
        pop_log.delete();
    endtask

    initial begin
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        inst_ready     = 1'b0;
        @(posedge clk);
        #1;

        // Decode stalled: exactly two fetches, then resume in order.
        do_reset(2);
        repeat (6) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1, 1'b0);
        chk("stall_acc_count", acc_log.size(), 2);
        chk("stall_req_vld", obs_req_vld, 1'b0);
        chk("stall_inst_vld", obs_inst_vld, 1'b1);
        chk("stall_inst_pc", obs_inst_pc, 32'h0);
        repeat (8) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1, 1'b0);
        chk("resume_addr", (acc_log.size() > 2) ? acc_log[2] : 32'hFFFF_FFFF, 32'h8);
        for (int i = 0; i < 4; i++)
            chk("resume_pop_pc", (pop_log.size() > i) ? pop_log[i] : 32'hFFFF_FFFF, 32'(i * 4));

        // Memory not ready for three cycles: request held stable.
        do_reset(2);
        repeat (3) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1, 1'b0);
            chk("hold_vld", obs_req_vld, 1'b1);
            chk("hold_addr", obs_req_addr, 32'h0);
        end
        chk("hold_no_acc", acc_log.size(), 0);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1, 1'b0);
        chk("hold_acc", acc_log.size(), 1);
        chk("hold_acc_addr", (acc_log.size() > 0) ? acc_log[0] : 32'hFFFF_FFFF, 32'h0);

        // Redirect with two fetches in flight.
        do_reset(2);
        cycle(1'b0, 1'b1, 32'h10, 1'b1, 1'b1, 1, 1'b0);
        repeat (2) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 3, 1'b0);
        chk("two_inflight", acc_log.size(), 2);
        chk("inflight_addr1", (acc_log.size() > 1) ? acc_log[1] : 32'hFFFF_FFFF, 32'h14);
        cycle(1'b0, 1'b1, 32'h103, 1'b1, 1'b1, 1, 1'b0);
        acc_log.delete();
        repeat (8) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1, 1'b0);
        chk("redir_addr", (acc_log.size() > 0) ? acc_log[0] : 32'hFFFF_FFFF, 32'h100);
        chk("redir_inst_vld", obs_inst_vld, 1'b1);
        chk("redir_inst_pc", obs_inst_pc, 32'h100);
        chk("redir_inst", obs_inst, word_of(32'h100));

        // Redirect coinciding with a response and a decode pop.
        do_reset(2);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 2, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1, 1'b0);
        cycle(1'b0, 1'b1, 32'h41, 1'b0, 1'b1, 1, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1, 1'b0);
        chk("flush_inst_vld", obs_inst_vld, 1'b0);
        chk("flush_no_pop", pop_log.size(), 0);
        chk("flush_req_vld", obs_req_vld, 1'b1);
        chk("flush_req_addr", obs_req_addr, 32'h40);
        repeat (4) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1, 1'b0);
        chk("flush_first_pc", (pop_log.size() > 0) ? pop_log[0] : 32'hFFFF_FFFF, 32'h40);

        // Reset with fetches in flight; late responses must be ignored.
        do_reset(2);
        repeat (2) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 4, 1'b0);
        do_reset(2);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1, 1'b0);
        chk("late_inst_vld", obs_inst_vld, 1'b0);
        chk("late_req_addr", obs_req_addr, RESET_PC);
        repeat (6) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1, 1'b0);
        chk("late_restart", (acc_log.size() > 0) ? acc_log[0] : 32'hFFFF_FFFF, RESET_PC);
        chk("late_inst_pc", obs_inst_pc, RESET_PC);
        chk("late_inst", obs_inst, word_of(RESET_PC));

        repeat (3000) begin
            cycle($urandom_range(0, 199) == 0, $urandom_range(0, 11) == 0, $urandom,
                  $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
                  $urandom_range(1, 4), $urandom_range(0, 4) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
